pc_sequencer: RTL and testbench

- Owns the program counter and sequences the front of the RV32IM pipeline.
- Arbitrates between four events: EX-stage branch/jump redirects, load-use stalls, instruction-memory wait states and data-memory wait states.
- Drives the PC register and the hold/flush controls of the IF/ID and ID/EX pipeline registers.
- Sits between the branch/jump resolution logic in EX, the hazard detector in ID and both memory interfaces.

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter owner and front-end pipeline sequencer for the RV32IM core.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect targets vector to TRAP_VECTOR.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        LOAD_USE_STALL,
    input  logic        IMEM_BUSY,
    input  logic        DMEM_BUSY,
    output logic [31:0] PC,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        MISALIGN_FAULT,
`endif
    output logic        PIPE_FREEZE,
    output logic        IF_ID_HOLD,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] target_q, target_n;
    logic        load;
    logic [31:0] load_addr;
    logic        hold_raw;
    logic        if_id_flush_c;
    logic        id_ex_flush_c;
    logic        freeze_c;
    logic        fault_n;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= BOOT;
            pc_q     <= RESET_VECTOR;
            target_q <= '0;
        end else begin
            state    <= state_n;
            pc_q     <= pc_n;
            target_q <= target_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc_q;
        target_n      = target_q;
        load          = 1'b0;
        load_addr     = target_q;
        hold_raw      = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        freeze_c      = 1'b0;
        fault_n       = 1'b0;

        case (state)
            BOOT: begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                state_n       = RUN;
            end
            RUN: begin
                if (DMEM_BUSY) begin
                    freeze_c = 1'b1;
                    hold_raw = 1'b1;
                end else if (REDIRECT) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (!IMEM_BUSY) begin
                        load      = 1'b1;
                        load_addr = REDIRECT_PC;
                    end else begin
                        target_n = REDIRECT_PC;
                        state_n  = PENDING;
                    end
                end else if (LOAD_USE_STALL) begin
                    hold_raw      = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (IMEM_BUSY) begin
                    if_id_flush_c = 1'b1;
                end else begin
                    pc_n = pc_q + PC_STEP;
                end
            end
            PENDING: begin
                if_id_flush_c = 1'b1;
                if (DMEM_BUSY) begin
                    freeze_c = 1'b1;
                    hold_raw = 1'b1;
                end else if (REDIRECT) begin
                    // A newer redirect supersedes the captured target.
                    id_ex_flush_c = 1'b1;
                    if (!IMEM_BUSY) begin
                        load      = 1'b1;
                        load_addr = REDIRECT_PC;
                        state_n   = RUN;
                    end else begin
                        target_n = REDIRECT_PC;
                    end
                end else if (!IMEM_BUSY) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            default: begin
                state_n = BOOT;
            end
        endcase

        if (load) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (load_addr[1:0] != 2'b00) begin
                pc_n    = TRAP_VECTOR;
                fault_n = 1'b1;
            end else begin
                pc_n = load_addr;
            end
`else
            pc_n = load_addr;
`endif
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MISALIGN_FAULT <= 1'b0;
        end else begin
            MISALIGN_FAULT <= fault_n;
        end
    end
`endif

    assign PC          = pc_q;
    assign PIPE_FREEZE = freeze_c;
    // A flush of IF/ID overrides any request to hold it.
    assign IF_ID_HOLD  = hold_raw & ~if_id_flush_c;
    assign IF_ID_FLUSH = if_id_flush_c;
    assign ID_EX_FLUSH = id_ex_flush_c;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        LOAD_USE_STALL;
    logic        IMEM_BUSY;
    logic        DMEM_BUSY;
    logic [31:0] PC;
    logic        PIPE_FREEZE;
    logic        IF_ID_HOLD;
    logic        IF_ID_FLUSH;
    logic        ID_EX_FLUSH;
`ifdef PC_MISALIGN_TRAP_EN
    logic        MISALIGN_FAULT;
`endif

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .PC_STEP     (32'd4),
        .TRAP_VECTOR (32'h0000_0100)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .REDIRECT      (REDIRECT),
        .REDIRECT_PC   (REDIRECT_PC),
        .LOAD_USE_STALL(LOAD_USE_STALL),
        .IMEM_BUSY     (IMEM_BUSY),
        .DMEM_BUSY     (DMEM_BUSY),
        .PC            (PC),
`ifdef PC_MISALIGN_TRAP_EN
        .MISALIGN_FAULT(MISALIGN_FAULT),
`endif
        .PIPE_FREEZE   (PIPE_FREEZE),
        .IF_ID_HOLD    (IF_ID_HOLD),
        .IF_ID_FLUSH   (IF_ID_FLUSH),
        .ID_EX_FLUSH   (ID_EX_FLUSH)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Flags packed as {PIPE_FREEZE, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_FLUSH}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, PIPE_FREEZE, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_FLUSH}, {28'd0, exp});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_N        = 1'b0;
        REDIRECT       = 1'b0;
        REDIRECT_PC    = '0;
        LOAD_USE_STALL = 1'b0;
        IMEM_BUSY      = 1'b0;
        DMEM_BUSY      = 1'b0;
        #2;
        chk("reset_pc", PC, 32'h0);
        chk_ctl("reset_ctl", 4'b0011);
`ifdef PC_MISALIGN_TRAP_EN
        chk("reset_fault", {31'd0, MISALIGN_FAULT}, 32'd0);
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("boot_pc", PC, 32'h0);
        chk_ctl("boot_ctl", 4'b0011);

        // Sequential fetch from the reset vector
        step(); chk("seq0", PC, 32'h0); chk_ctl("run_ctl", 4'b0000);
        step(); chk("seq4", PC, 32'h4);
        step(); chk("seq8", PC, 32'h8);
        step(); chk("seqC", PC, 32'hC);
        repeat (5) step();
        chk("seq20", PC, 32'h20);

        // Redirect with instruction memory ready
        REDIRECT = 1'b1; REDIRECT_PC = 32'h100; #1;
        chk_ctl("redir_ctl", 4'b0011);
        step(); REDIRECT = 1'b0; #1;
        chk("redir_pc", PC, 32'h100);
        chk_ctl("redir_after_ctl", 4'b0000);
        step(); chk("redir_seq", PC, 32'h104);

        // Load-use stall at 0x40
        REDIRECT = 1'b1; REDIRECT_PC = 32'h40;
        step(); REDIRECT = 1'b0; #1;
        chk("lu_start_pc", PC, 32'h40);
        LOAD_USE_STALL = 1'b1; #1;
        chk_ctl("lu_ctl", 4'b0101);
        step(); LOAD_USE_STALL = 1'b0; #1;
        chk("lu_held_pc", PC, 32'h40);
        step(); chk("lu_resume_pc", PC, 32'h44);

        // Redirect while instruction memory busy: three pending cycles
        REDIRECT = 1'b1; REDIRECT_PC = 32'h200; IMEM_BUSY = 1'b1; #1;
        chk_ctl("pend_accept_ctl", 4'b0011);
        step(); REDIRECT = 1'b0; #1;
        chk("pend1_pc", PC, 32'h44); chk_ctl("pend1_ctl", 4'b0010);
        step(); chk("pend2_pc", PC, 32'h44); chk_ctl("pend2_ctl", 4'b0010);
        step(); chk("pend3_pc", PC, 32'h44); chk_ctl("pend3_ctl", 4'b0010);
        IMEM_BUSY = 1'b0; #1;
        chk_ctl("pend_release_ctl", 4'b0010);
        step(); chk("pend_target_pc", PC, 32'h200); chk_ctl("pend_done_ctl", 4'b0000);
        step(); chk("pend_seq_pc", PC, 32'h204);

        // Data memory freeze masks redirect and load-use
        DMEM_BUSY = 1'b1; REDIRECT = 1'b1; REDIRECT_PC = 32'h280; LOAD_USE_STALL = 1'b1; #1;
        chk_ctl("freeze1_ctl", 4'b1100);
        step(); chk("freeze1_pc", PC, 32'h204); chk_ctl("freeze2_ctl", 4'b1100);
        step(); chk("freeze2_pc", PC, 32'h204);
        DMEM_BUSY = 1'b0; #1;
        chk_ctl("unfreeze_ctl", 4'b0011);
        step(); REDIRECT = 1'b0; LOAD_USE_STALL = 1'b0; #1;
        chk("unfreeze_pc", PC, 32'h280);

        // Instruction wait state alone
        IMEM_BUSY = 1'b1; #1;
        chk_ctl("iwait_ctl", 4'b0010);
        step(); IMEM_BUSY = 1'b0; #1;
        chk("iwait_pc", PC, 32'h280);
        step(); chk("iwait_resume_pc", PC, 32'h284);

        // Latest redirect in PENDING wins
        REDIRECT = 1'b1; REDIRECT_PC = 32'h300; IMEM_BUSY = 1'b1;
        step(); REDIRECT_PC = 32'h380; #1;
        chk_ctl("pend_redir_ctl", 4'b0011);
        step(); REDIRECT = 1'b0; IMEM_BUSY = 1'b0;
        step(); chk("latest_wins_pc", PC, 32'h380);

        // PC wraps modulo 2^32
        REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC;
        step(); REDIRECT = 1'b0; #1;
        chk("wrap_top_pc", PC, 32'hFFFF_FFFC);
        step(); chk("wrap_pc", PC, 32'h0);

        // Misaligned redirect target
        REDIRECT = 1'b1; REDIRECT_PC = 32'h102;
        step(); REDIRECT = 1'b0; #1;
`ifdef PC_MISALIGN_TRAP_EN
        chk("trap_pc", PC, 32'h100);
        chk("trap_fault", {31'd0, MISALIGN_FAULT}, 32'd1);
        step();
        chk("trap_fault_clear", {31'd0, MISALIGN_FAULT}, 32'd0);
        chk("trap_seq_pc", PC, 32'h104);
`else
        chk("misalign_pc", PC, 32'h102);
        step(); chk("misalign_seq_pc", PC, 32'h106);
`endif

        // Reset in PENDING discards the captured target
        REDIRECT = 1'b1; REDIRECT_PC = 32'h300; IMEM_BUSY = 1'b1;
        step(); REDIRECT = 1'b0; #1;
        chk_ctl("pre_reset_pend_ctl", 4'b0010);
        @(negedge CLK);
        RESET_N = 1'b0; #1;
        chk("midreset_pc", PC, 32'h0);
        chk_ctl("midreset_ctl", 4'b0011);
        IMEM_BUSY = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1; #1;
        chk_ctl("reboot_ctl", 4'b0011);
        step(); chk("reboot_seq0", PC, 32'h0); chk_ctl("reboot_run_ctl", 4'b0000);
        step(); chk("reboot_seq4", PC, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
